cla32_rr_sched: RTL and testbench
=================================

# cla32_rr_sched

Round-robin scheduler that shares one `CLA32` adder instance among `N_REQ` requesters. It accepts one operand pair per transaction over a valid/ready handshake and drives the pair into the adder from registers. It captures the 33-bit sum and returns it with the requester ID on a valid/ready response port. It sits between the requesting datapath blocks and the single shared `CLA32`.

## Interface
- `N_REQ`, default 4, number of requesters; range 2..8.
- `ID_W`, default 2, requester ID width; equals ceil(log2(`N_REQ`)).
- `clk` input, 1 bit: rising-edge clock.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `req_valid` input, `N_REQ` bits: per-requester request valid.
- `req_a` input, `N_REQ`*32 bits: operand A. Requester i uses bits [32i+31:32i].
- `req_b` input, `N_REQ`*32 bits: operand B, same packing as `req_a`.
- `req_ready` output, `N_REQ` bits: one-hot grant. Accepts the request this cycle.
- `rsp_valid` output, 1 bit: response holds a result.
- `rsp_sum` output, 33 bits: `a + b`, zero-extended; bit 32 is the carry-out.
- `rsp_id` output, `ID_W` bits: index of the requester that issued the operands.
- `rsp_ready` input, 1 bit: consumer accepts the response.
- `busy` output, 1 bit: state is not IDLE.
- `ops_done` output, 16 bits: count of completed response handshakes; wraps at 0xFFFF -> 0.

## Operation
- FSM states:
  - IDLE: grant the next requester and load its operands.
  - CALC: the adder settles on the registered operands.
  - HOLD: the result is presented until it is accepted.
- IDLE:
  - Round-robin search from `rr_ptr` upward, modulo `N_REQ`. The first set `req_valid` bit is the winner.
  - Combinationally raise `req_ready[winner]`. All other `req_ready` bits are 0.
  - If no request is valid, `req_ready` is 0 and the state stays IDLE.
  - On an accepted grant, at the clock edge:
    - `op_a`/`op_b` <= the winner's operands.
    - `op_id` <= winner.
    - `rr_ptr` <= (winner+1) mod `N_REQ`.
    - state -> CALC.
- CALC:
  - `req_ready` is all 0.
  - At the edge: `rsp_sum` <= `CLA32(op_a, op_b)`, `rsp_id` <= `op_id`, `rsp_valid` <= 1, state -> HOLD.
- HOLD:
  - `rsp_sum` and `rsp_id` stay stable while `rsp_valid`=1.
  - On `rsp_valid && rsp_ready` at the edge: `rsp_valid` <= 0, `ops_done` increments, state -> IDLE.
- Arithmetic:
  - The 33-bit result is exact; there is no truncation.
  - 0xFFFFFFFF + 0xFFFFFFFF = 0x1_FFFFFFFE.
- A requester that drops `req_valid` before it is granted loses nothing; it is simply not selected.
- Fairness: a continuously valid requester is granted within `N_REQ` transactions.
- Reset (`rst_n`=0 at an edge), from any state:
  - state = IDLE, `rr_ptr` = 0.
  - `rsp_valid` = 0, `rsp_sum` = 0, `rsp_id` = 0.
  - `ops_done` = 0, `busy` = 0.
  - `req_ready` = 0 while `rst_n` is low.
  - An in-flight transaction is discarded and produces no response.

## Timing
- Accept at edge k → `rsp_valid` high after edge k+1 (latency: 1 cycle after acceptance).
- With `rsp_ready` tied high:
  - The handshake completes at edge k+2.
  - The next accept is possible at edge k+3.
  - Peak throughput is one operation per 3 cycles.
- `rsp_ready` held low keeps the block in HOLD indefinitely. No new grants are issued.
- `req_ready` depends combinationally on `req_valid` and state only. It never depends on `rsp_ready`.
- The `CLA32` path is register-to-register: `op_*` → `rsp_sum`, one full cycle.

## Structure
- Package `cla_sched_pkg` holds:
  - state enum `sched_state_t` {IDLE, CALC, HOLD};
  - constant `CLA_W` = 32;
  - constant `SUM_W` = 33;
  - constant `CNT_W` = 16.
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: `req_valid`, `rr_ptr`.
  - Outputs: `grant_oh`, `grant_idx`, `any`.
- The existing `CLA32` is instantiated exactly once, unmodified.

## Test plan
- Single request: requester 2 sends a=5, b=7 with `rsp_ready`=1.
  - `req_ready`=0b0100 for one cycle.
  - `rsp_sum`=12, `rsp_id`=2 after 1 cycle.
  - `ops_done`=1.
- Carry-out: a=0xFFFFFFFF, b=0x00000001 → `rsp_sum`=0x1_00000000.
  - a=b=0xFFFFFFFF → `rsp_sum`=0x1_FFFFFFFE.
- Fairness: all 4 requesters hold `req_valid`=1 from reset.
  - Grant order is 0,1,2,3,0,1.
  - Responses arrive every 3 cycles with matching IDs and sums.
- Backpressure: hold `rsp_ready`=0 for 10 cycles with a response pending.
  - `rsp_valid`, `rsp_sum` and `rsp_id` stay stable, `req_ready`=0, `busy`=1.
  - Raising `rsp_ready` completes the handshake in one cycle.
- Reset mid-operation: drive `rst_n`=0 during CALC.
  - Next edge: `rsp_valid`=0, `ops_done`=0, `rr_ptr`=0, no stale response.
  - First request after reset completes normally.
- Randomized soak: 1000 random requests from random requesters with random `rsp_ready`.
  - Every response equals the 33-bit golden a+b for its ID.
  - No request is lost or duplicated.
  - `ops_done` equals the accepted count mod 65536.

Source files
------------

// File: rtl/cla32_rr_sched_pkg.sv
// Shared types and widths for the round-robin scheduler around the shared CLA32 adder.
package cla_sched_pkg;

  localparam int CLA_W = 32;
  localparam int SUM_W = 33;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

endpackage

// File: rtl/cla32_rr_sched_if.sv
// Request/response bundle between the requesting blocks (master) and the scheduler (slave).
interface cla32_rr_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);

  logic [N_REQ-1:0]                        req_valid;
  logic [N_REQ-1:0]                        req_ready;
  logic [N_REQ*cla_sched_pkg::CLA_W-1:0]   req_a;
  logic [N_REQ*cla_sched_pkg::CLA_W-1:0]   req_b;
  logic                                    rsp_valid;
  logic                                    rsp_ready;
  logic [cla_sched_pkg::SUM_W-1:0]         rsp_sum;
  logic [ID_W-1:0]                         rsp_id;
  logic                                    busy;
  logic [cla_sched_pkg::CNT_W-1:0]         ops_done;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id, busy, ops_done
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id, busy, ops_done
  );

endinterface

// File: rtl/cla32.sv
// Existing 32-bit carry-lookahead adder: 4-bit lookahead groups joined by a group-carry chain.
module CLA32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    logic [3:0] gk;
    logic [3:0] pk;
    logic [3:0] ck;

    assign gk = g[4*k +: 4];
    assign pk = p[4*k +: 4];

    assign gg[k] = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1])
                 | (pk[3] & pk[2] & pk[1] & gk[0]);
    assign gp[k] = &pk;

    // In-group carries are computed from the group carry-in only, not from each other.
    assign ck[0] = gc[k];
    assign ck[1] = gk[0] | (pk[0] & gc[k]);
    assign ck[2] = gk[1] | (pk[1] & gk[0]) | (pk[1] & pk[0] & gc[k]);
    assign ck[3] = gk[2] | (pk[2] & gk[1]) | (pk[2] & pk[1] & gk[0])
                 | (pk[2] & pk[1] & pk[0] & gc[k]);

    assign sum[4*k +: 4] = pk ^ ck;
  end

  always_comb begin
    gc[0] = cin;
    for (int k = 0; k < 8; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
  end

  assign cout = gc[8];

endmodule

// File: rtl/cla32_rr_sched_rr_pick.sv
// Combinational round-robin picker: first set req_valid bit at or above rr_ptr, modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any
);

  logic [ID_W:0] pos;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    pos       = '0;
    // Walk from the farthest offset back to rr_ptr so the nearest valid requester wins last.
    for (int off = N_REQ - 1; off >= 0; off--) begin
      pos = {1'b0, rr_ptr} + (ID_W+1)'(off);
      if (pos >= (ID_W+1)'(N_REQ)) begin
        pos = pos - (ID_W+1)'(N_REQ);
      end
      if (req_valid[pos[ID_W-1:0]]) begin
        grant_idx = pos[ID_W-1:0];
        any       = 1'b1;
      end
    end
    grant_oh[grant_idx] = any;
  end

endmodule

// File: rtl/cla32_rr_sched.sv
// Shares one CLA32 among N_REQ requesters: grant in IDLE, add in CALC, hold the result in HOLD.
module cla32_rr_sched
  import cla_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  cla32_rr_sched_if.slave  bus
);

  sched_state_t     state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  next_ptr;
  logic [ID_W-1:0]  op_id;
  logic [ID_W-1:0]  grant_idx;
  logic [N_REQ-1:0] grant_oh;
  logic             any_req;
  logic             accept;
  logic [CLA_W-1:0] op_a;
  logic [CLA_W-1:0] op_b;
  logic [CLA_W-1:0] sel_a;
  logic [CLA_W-1:0] sel_b;
  logic [CLA_W-1:0] cla_sum;
  logic             cla_cout;
  logic             rsp_valid;
  logic [SUM_W-1:0] rsp_sum;
  logic [ID_W-1:0]  rsp_id;
  logic [CNT_W-1:0] ops_done;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  assign accept   = (state == IDLE) && any_req;
  assign next_ptr = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = bus.req_a[i*CLA_W +: CLA_W];
        sel_b = bus.req_b[i*CLA_W +: CLA_W];
      end
    end
  end

  // NOTE: operand registers are pure datapath and carry no reset; state guarantees they are loaded before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a <= sel_a;
      op_b <= sel_b;
    end
  end

  CLA32 u_cla (
    .a    (op_a),
    .b    (op_b),
    .cin  (1'b0),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      ops_done  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            op_id  <= grant_idx;
            rr_ptr <= next_ptr;
            state  <= CALC;
          end
        end
        CALC: begin
          rsp_sum   <= {cla_cout, cla_sum};
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (rsp_valid && bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grants are suppressed while reset is held, independent of the current state register.
  assign bus.req_ready = (rst_n && state == IDLE) ? grant_oh : '0;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_sum   = rsp_sum;
  assign bus.rsp_id    = rsp_id;
  assign bus.busy      = (state != IDLE);
  assign bus.ops_done  = ops_done;

endmodule

// File: tb/tb_cla32_rr_sched.sv
// Self-checking bench for cla32_rr_sched: directed scenarios plus a randomized soak against a transaction model.
module tb_cla32_rr_sched;
  import cla_sched_pkg::*;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;
  int model_ops = 0;

  cla32_rr_sched_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  cla32_rr_sched #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [N_REQ-1:0] onehot(input int idx);
    logic [N_REQ-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [32:0] golden(input logic [31:0] a, input logic [31:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[id*32 +: 32] = a;
    bus.req_b[id*32 +: 32] = b;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    model_ptr = 0;
    model_ops = 0;
  endtask

  // Single transaction from requester id with rsp_ready high; bounded waits on grant and response.
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] exp_sum;
    int n;
    exp_sum = golden(a, b);
    @(negedge clk);
    set_op(id, a, b);
    bus.req_valid = onehot(id);
    bus.rsp_ready = 1'b1;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 8) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (bus.req_ready !== onehot(id))
      begin errors++; $display("FAIL op_grant id%0d: got %b expected %b", id, bus.req_ready, onehot(id)); end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    n = 0;
    while (!bus.rsp_valid && n < 8) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (bus.rsp_sum !== exp_sum || bus.rsp_valid !== 1'b1)
      begin errors++; $display("FAIL op_sum id%0d: got valid=%b sum=%h expected sum=%h", id, bus.rsp_valid, bus.rsp_sum, exp_sum); end
    checks++;
    if (bus.rsp_id !== ID_W'(id))
      begin errors++; $display("FAIL op_id: got %0d expected %0d", bus.rsp_id, id); end
    model_ops++;
    model_ptr = (id + 1) % N_REQ;
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.ops_done !== 16'(model_ops))
      begin errors++; $display("FAIL op_done: got valid=%b ops=%0d expected valid=0 ops=%0d", bus.rsp_valid, bus.ops_done, model_ops); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready); end
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++;
    if (bus.rsp_sum !== '0 || bus.rsp_id !== '0)
      begin errors++; $display("FAIL reset_rsp_data: got sum=%h id=%0d expected 0", bus.rsp_sum, bus.rsp_id); end
    checks++;
    if (bus.ops_done !== '0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL reset_counters: got ops=%0d busy=%b expected 0", bus.ops_done, bus.busy); end
    @(negedge clk);
    idle_inputs();
    rst_n     = 1'b1;
    model_ptr = 0;
    model_ops = 0;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_op(2, 32'd5, 32'd7);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    checks++;
    if (bus.req_ready !== '0 || bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0)
      begin errors++; $display("FAIL single_calc: got ready=%b busy=%b valid=%b expected 0/1/0", bus.req_ready, bus.busy, bus.rsp_valid); end
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 33'd12 || bus.rsp_id !== 2'd2)
      begin errors++; $display("FAIL single_rsp: got valid=%b sum=%0d id=%0d expected 1/12/2", bus.rsp_valid, bus.rsp_sum, bus.rsp_id); end
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.ops_done !== 16'd1 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL single_done: got valid=%b ops=%0d busy=%b expected 0/1/0", bus.rsp_valid, bus.ops_done, bus.busy); end
    model_ops = 1;
    model_ptr = 3;
  endtask

  task automatic test_carry();
    do_op(3, 32'hFFFF_FFFF, 32'h0000_0001);
    do_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(0, 32'h0000_0000, 32'h0000_0000);
  endtask

  task automatic test_fairness();
    logic [31:0] fa [N_REQ];
    logic [31:0] fb [N_REQ];
    int order [6] = '{0, 1, 2, 3, 0, 1};
    int gq [$];
    int grants = 0, resps = 0, last_g = -1, last_r = -1, cyc = 0;
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) begin
      fa[i] = rand_op();
      fb[i] = rand_op();
      set_op(i, fa[i], fb[i]);
    end
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    apply_reset();
    while ((grants < 6 || resps < 6) && cyc < 40) begin
      if (cyc > 0) begin
        @(negedge clk);
        if (grants == 6) bus.req_valid = '0;
      end
      #1;
      if (bus.req_ready != '0) begin
        checks++;
        if (grants >= 6) begin
          errors++; $display("FAIL fair_extra_grant: got %b expected none", bus.req_ready);
        end else begin
          if (bus.req_ready !== onehot(order[grants]))
            begin errors++; $display("FAIL fair_order #%0d: got %b expected %b", grants, bus.req_ready, onehot(order[grants])); end
          if (last_g >= 0) begin
            checks++;
            if (cyc - last_g != 3) begin errors++; $display("FAIL fair_grant_gap: got %0d expected 3", cyc - last_g); end
          end
          gq.push_back(order[grants]);
          last_g = cyc;
          grants++;
        end
      end
      if (bus.rsp_valid) begin
        checks++;
        if (gq.size() == 0) begin
          errors++; $display("FAIL fair_stray_rsp: got id=%0d expected no response", bus.rsp_id);
        end else begin
          if (bus.rsp_id !== ID_W'(gq[0]) || bus.rsp_sum !== golden(fa[gq[0]], fb[gq[0]]))
            begin errors++; $display("FAIL fair_rsp: got id=%0d sum=%h expected id=%0d sum=%h", bus.rsp_id, bus.rsp_sum, gq[0], golden(fa[gq[0]], fb[gq[0]])); end
          if (last_r >= 0) begin
            checks++;
            if (cyc - last_r != 3) begin errors++; $display("FAIL fair_rsp_gap: got %0d expected 3", cyc - last_r); end
          end
          void'(gq.pop_front());
        end
        last_r = cyc;
        resps++;
        model_ops++;
      end
      cyc++;
    end
    checks++;
    if (cyc >= 40) begin errors++; $display("FAIL fair_timeout: got grants=%0d rsps=%0d expected 6/6", grants, resps); end
    @(negedge clk); #1;
    checks++;
    if (bus.ops_done !== 16'(model_ops)) begin errors++; $display("FAIL fair_ops: got %0d expected %0d", bus.ops_done, model_ops); end
    idle_inputs();
    model_ptr = 2;
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    a = rand_op();
    b = rand_op();
    idle_inputs();
    apply_reset();
    set_op(0, a, b);
    bus.req_valid = 4'b0001;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant: got %b expected 0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '1;
    #1;
    checks++;
    if (bus.req_ready !== '0) begin errors++; $display("FAIL bp_calc_ready: got %b expected 0", bus.req_ready); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== golden(a, b) || bus.rsp_id !== 2'd0)
        begin errors++; $display("FAIL bp_hold_rsp cyc%0d: got valid=%b sum=%h id=%0d expected 1/%h/0", i, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, golden(a, b)); end
      checks++;
      if (bus.req_ready !== '0 || bus.busy !== 1'b1)
        begin errors++; $display("FAIL bp_hold_state cyc%0d: got ready=%b busy=%b expected 0/1", i, bus.req_ready, bus.busy); end
    end
    @(negedge clk);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.ops_done !== 16'd1 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL bp_release: got valid=%b ops=%0d busy=%b expected 0/1/0", bus.rsp_valid, bus.ops_done, bus.busy); end
    model_ops = 1;
    model_ptr = 1;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    idle_inputs();
    apply_reset();
    set_op(1, rand_op(), rand_op());
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    rst_n         = 1'b0;
    bus.req_valid = '1;
    #1;
    checks++;
    if (bus.req_ready !== '0) begin errors++; $display("FAIL rmid_ready_in_reset: got %b expected 0", bus.req_ready); end
    @(negedge clk);
    rst_n         = 1'b1;
    bus.req_valid = '0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.ops_done !== '0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL rmid_after_reset: got valid=%b ops=%0d busy=%b expected 0/0/0", bus.rsp_valid, bus.ops_done, bus.busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale_rsp cyc%0d: got %b expected 0", i, bus.rsp_valid); end
    end
    model_ptr = 0;
    model_ops = 0;
    // With rr_ptr back at 0, requester 1 must win over requester 3.
    a = rand_op();
    b = rand_op();
    @(negedge clk);
    set_op(1, a, b);
    set_op(3, rand_op(), rand_op());
    bus.req_valid = 4'b1010;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_ptr: got %b expected 0010", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== golden(a, b) || bus.rsp_id !== 2'd1)
      begin errors++; $display("FAIL rmid_first_op: got valid=%b sum=%h id=%0d expected 1/%h/1", bus.rsp_valid, bus.rsp_sum, bus.rsp_id, golden(a, b)); end
    @(negedge clk); #1;
    checks++;
    if (bus.ops_done !== 16'd1) begin errors++; $display("FAIL rmid_ops: got %0d expected 1", bus.ops_done); end
    idle_inputs();
  endtask

  task automatic test_soak();
    logic [31:0] pa [N_REQ];
    logic [31:0] pb [N_REQ];
    bit          pv [N_REQ];
    int          exp_id_q [$];
    logic [32:0] exp_sum_q [$];
    logic [N_REQ-1:0] exp_rdy;
    bit inflight = 0;
    int age = 0, created = 0, completed = 0, cyc = 0, w;
    bit rsp_exp;
    idle_inputs();
    apply_reset();
    for (int i = 0; i < N_REQ; i++) pv[i] = 0;
    while (completed < 1000 && cyc < 20000) begin
      if (cyc > 0) @(negedge clk);
      for (int i = 0; i < N_REQ; i++) begin
        if (pv[i] && $urandom_range(0, 15) == 0) begin
          pv[i] = 0;
          created--;
        end else if (!pv[i] && created < 1000 && $urandom_range(0, 2) == 0) begin
          pv[i] = 1;
          pa[i] = rand_op();
          pb[i] = rand_op();
          created++;
        end
        bus.req_valid[i] = pv[i];
        set_op(i, pa[i], pb[i]);
      end
      bus.rsp_ready = 1'($urandom_range(0, 1));
      #1;
      w = -1;
      if (!inflight) begin
        for (int off = N_REQ - 1; off >= 0; off--) begin
          if (pv[(model_ptr + off) % N_REQ]) w = (model_ptr + off) % N_REQ;
        end
      end
      exp_rdy = onehot(w);
      rsp_exp = inflight && age >= 1;
      checks++;
      if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL soak_grant cyc%0d: got %b expected %b", cyc, bus.req_ready, exp_rdy); end
      checks++;
      if (bus.busy !== inflight || bus.rsp_valid !== rsp_exp)
        begin errors++; $display("FAIL soak_status cyc%0d: got busy=%b valid=%b expected %b/%b", cyc, bus.busy, bus.rsp_valid, inflight, rsp_exp); end
      if (rsp_exp) begin
        checks++;
        if (bus.rsp_id !== ID_W'(exp_id_q[0]) || bus.rsp_sum !== exp_sum_q[0])
          begin errors++; $display("FAIL soak_rsp cyc%0d: got id=%0d sum=%h expected id=%0d sum=%h", cyc, bus.rsp_id, bus.rsp_sum, exp_id_q[0], exp_sum_q[0]); end
      end
      checks++;
      if (bus.ops_done !== 16'(model_ops)) begin errors++; $display("FAIL soak_ops cyc%0d: got %0d expected %0d", cyc, bus.ops_done, model_ops); end
      if (w >= 0) begin
        exp_id_q.push_back(w);
        exp_sum_q.push_back(golden(pa[w], pb[w]));
        inflight  = 1;
        age       = 0;
        model_ptr = (w + 1) % N_REQ;
        pv[w]     = 0;
      end else if (inflight) begin
        if (rsp_exp && bus.rsp_ready) begin
          void'(exp_id_q.pop_front());
          void'(exp_sum_q.pop_front());
          inflight = 0;
          model_ops++;
          completed++;
        end else begin
          age++;
        end
      end
      cyc++;
    end
    checks++;
    if (cyc >= 20000) begin errors++; $display("FAIL soak_timeout: got %0d completions expected 1000", completed); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (bus.ops_done !== 16'd1000 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL soak_final: got ops=%0d busy=%b expected 1000/0", bus.ops_done, bus.busy); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_carry();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
